// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, range/alignment-checks it, buffers words in a small FIFO
// and hands them to decode over valid/ready. Redirects flush the buffer and restart fetch.
//
//   state | meaning
//   RUN   | fetching permitted (subject to fetch_en and FIFO space)
//   HALT  | a fault entry was queued; no fetch until the next redirect
module instr_fetch_ctrl #(
  parameter logic [31:0] INIT_PC    = 32'h0000_3000,
  parameter int          IMEM_WORDS = 1024,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault,
  output logic [31:0] fetch_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] IMEM_END = {1'b0, INIT_PC} + 33'(4 * IMEM_WORDS);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          not_empty, pop, push, fault;

  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic          buf_fault [FIFO_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    not_empty = (count != '0);
    fault     = (fpc < INIT_PC) || ({1'b0, fpc} >= IMEM_END) || (fpc[1:0] != 2'b00);
    pop       = not_empty & if_ready & ~redirect_valid;
    push      = (state_q == RUN) & fetch_en & ~redirect_valid & ((count < CW'(FIFO_DEPTH)) | pop);
    if (redirect_valid) begin
      state_d = RUN;
    end else if (push && fault) begin
      state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= RUN;
      fpc       <= INIT_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        fpc    <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          if (!fault) fpc <= fpc + 32'd4;
        end
        if (pop) begin
          rd_ptr    <= ptr_inc(rd_ptr);
          fetch_cnt <= fetch_cnt + 32'd1;
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  // Storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= fpc;
      buf_instr[wr_ptr] <= fault ? 32'h0 : imem_instr;
      buf_fault[wr_ptr] <= fault;
    end
  end

  assign imem_addr = fpc;
  assign if_valid  = not_empty & ~redirect_valid;
  assign if_pc     = not_empty ? buf_pc[rd_ptr] : 32'h0;
  assign if_instr  = not_empty ? buf_instr[rd_ptr] : 32'h0;
  assign if_fault  = not_empty & buf_fault[rd_ptr];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, hand-written corner sequences and a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] INIT_PC    = 32'h0000_3000;
  localparam int          IMEM_WORDS = 1024;
  localparam int          FIFO_DEPTH = 2;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;
  logic [31:0] fetch_cnt;

  instr_fetch_ctrl #(
    .INIT_PC   (INIT_PC),
    .IMEM_WORDS(IMEM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_fault      (if_fault),
    .fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [IMEM_WORDS];

  // Out-of-range reads return junk so a missed fault shows up as a wrong instruction.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - INIT_PC;
    if (a >= INIT_PC && off < 32'(4 * IMEM_WORDS)) return mem[off[11:2]];
    return a ^ 32'hA5A5_1234;
  endfunction

  always_comb imem_instr = mem_read(imem_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of delivered-to-be entries and a fetch pointer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fpc;
  bit          m_halt;
  logic [31:0] m_cnt;

  task automatic model_reset();
    q.delete();
    m_fpc  = INIT_PC;
    m_halt = 0;
    m_cnt  = 0;
  endtask

  task automatic model_check();
    chk("m_addr", imem_addr, m_fpc);
    chk("m_cnt", fetch_cnt, m_cnt);
    if (q.size() == 0) begin
      chk("m_valid_empty", {31'h0, if_valid}, 32'h0);
      chk("m_pc_empty", if_pc, 32'h0);
      chk("m_instr_empty", if_instr, 32'h0);
      chk("m_fault_empty", {31'h0, if_fault}, 32'h0);
    end else if (redirect_valid) begin
      chk("m_valid_redirect", {31'h0, if_valid}, 32'h0);
    end else begin
      chk("m_valid", {31'h0, if_valid}, 32'h1);
      chk("m_pc", if_pc, q[0].pc);
      chk("m_instr", if_instr, q[0].instr);
      chk("m_fault", {31'h0, if_fault}, {31'h0, q[0].fault});
    end
  endtask

  task automatic model_update();
    logic [31:0] off;
    ent_t        e;
    if (!reset_n) begin
      model_reset();
    end else if (redirect_valid) begin
      q.delete();
      m_fpc  = redirect_pc;
      m_halt = 0;
    end else begin
      if (q.size() > 0 && if_ready) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 1;
      end
      if (!m_halt && fetch_en && q.size() < FIFO_DEPTH) begin
        off = m_fpc - INIT_PC;
        if (m_fpc >= INIT_PC && off < 32'(4 * IMEM_WORDS) && m_fpc % 4 == 0) begin
          e = '{pc: m_fpc, instr: mem[off / 4], fault: 1'b0};
          m_fpc = m_fpc + 4;
        end else begin
          e = '{pc: m_fpc, instr: 32'h0, fault: 1'b1};
          m_halt = 1;
        end
        q.push_back(e);
      end
    end
  endtask

  // Called just after a falling edge: drive inputs, let them settle, compare against the model.
  task automatic apply(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #1;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic        fe;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    int          w;
    logic [31:0] addr;
    logic [31:0] cnt;
  } tvec_t;

  localparam int NV = 15;
  tvec_t tv [NV];

  initial begin
    logic [31:0] ecnt;
    logic [31:0] tgt;
    logic [31:0] rpc;
    int          sel;

    tv[0]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    -1, 32'h3000, 32'd0};
    tv[1]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3000,  0, 32'h3004, 32'd0};
    tv[2]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3004,  1, 32'h3008, 32'd1};
    tv[3]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008,  2, 32'h300C, 32'd2};
    tv[4]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008,  2, 32'h3010, 32'd2};
    tv[5]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008,  2, 32'h3010, 32'd2};
    tv[6]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008,  2, 32'h3010, 32'd2};
    tv[7]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008,  2, 32'h3010, 32'd2};
    tv[8]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3008,  2, 32'h3010, 32'd2};
    tv[9]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h300C,  3, 32'h3014, 32'd3};
    tv[10] = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3010,  4, 32'h3018, 32'd4};
    tv[11] = '{1'b1, 1'b1, 32'h3020, 1'b1, 1'b0, 32'h0,    -1, 32'h3018, 32'd4};
    tv[12] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    -1, 32'h3020, 32'd4};
    tv[13] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3020,  8, 32'h3024, 32'd4};
    tv[14] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3024,  9, 32'h3028, 32'd5};

    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    reset_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();

    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_fault", {31'h0, if_fault}, 32'h0);
    chk("rst_addr", imem_addr, INIT_PC);
    chk("rst_cnt", fetch_cnt, 32'h0);
    reset_n = 1'b1;

    // Streaming, backpressure and redirect-while-full.
    for (int i = 0; i < NV; i++) begin
      apply(tv[i].fe, tv[i].rv, tv[i].rpc, tv[i].rdy);
      chk($sformatf("tv%0d_valid", i), {31'h0, if_valid}, {31'h0, tv[i].v});
      if (tv[i].v) begin
        chk($sformatf("tv%0d_pc", i), if_pc, tv[i].pc);
        chk($sformatf("tv%0d_instr", i), if_instr, (tv[i].w < 0) ? 32'h0 : mem[tv[i].w]);
        chk($sformatf("tv%0d_fault", i), {31'h0, if_fault}, 32'h0);
      end
      chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_cnt", i), fetch_cnt, tv[i].cnt);
      advance();
    end

    // Last word then fall off the end of memory.
    apply(1, 1, 32'h3FFC, 1); advance();
    apply(1, 0, 0, 1);
    chk("end_addr0", imem_addr, 32'h3FFC);
    chk("end_valid0", {31'h0, if_valid}, 32'h0);
    advance();
    apply(1, 0, 0, 1);
    chk("end_pc1", if_pc, 32'h3FFC);
    chk("end_instr1", if_instr, mem[IMEM_WORDS-1]);
    chk("end_fault1", {31'h0, if_fault}, 32'h0);
    chk("end_addr1", imem_addr, 32'h4000);
    advance();
    apply(1, 0, 0, 1);
    chk("end_valid2", {31'h0, if_valid}, 32'h1);
    chk("end_pc2", if_pc, 32'h4000);
    chk("end_instr2", if_instr, 32'h0);
    chk("end_fault2", {31'h0, if_fault}, 32'h1);
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 1);
      chk("halt_valid", {31'h0, if_valid}, 32'h0);
      chk("halt_addr", imem_addr, 32'h4000);
      advance();
    end
    apply(1, 1, 32'h3000, 1); advance();
    apply(1, 0, 0, 1); chk("resume_addr", imem_addr, 32'h3000); advance();
    apply(1, 0, 0, 1);
    chk("resume_pc", if_pc, 32'h3000);
    chk("resume_instr", if_instr, mem[0]);
    advance();

    // Misaligned and below-base targets each yield one fault entry, then halt.
    for (int k = 0; k < 2; k++) begin
      tgt = (k == 0) ? 32'h3002 : 32'h0000;
      apply(1, 1, tgt, 1); advance();
      apply(1, 0, 0, 1);
      chk("flt_addr0", imem_addr, tgt);
      chk("flt_valid0", {31'h0, if_valid}, 32'h0);
      advance();
      apply(1, 0, 0, 1);
      chk("flt_valid1", {31'h0, if_valid}, 32'h1);
      chk("flt_fault1", {31'h0, if_fault}, 32'h1);
      chk("flt_pc1", if_pc, tgt);
      chk("flt_instr1", if_instr, 32'h0);
      ecnt = m_cnt + 1;
      advance();
      for (int j = 0; j < 2; j++) begin
        apply(1, 0, 0, 1);
        chk("flt_valid2", {31'h0, if_valid}, 32'h0);
        chk("flt_cnt2", fetch_cnt, ecnt);
        chk("flt_addr2", imem_addr, tgt);
        advance();
      end
    end

    // Reset with two entries buffered.
    apply(1, 1, 32'h3000, 0); advance();
    apply(1, 0, 0, 0); advance();
    apply(1, 0, 0, 0); chk("pre_rst_valid", {31'h0, if_valid}, 32'h1); advance();
    reset_n = 1'b0;
    apply(1, 0, 0, 0); advance();
    reset_n = 1'b1;
    apply(1, 0, 0, 1);
    chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_rst_cnt", fetch_cnt, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h3000);
    advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rpc = INIT_PC + 32'(4 * IMEM_WORDS) - 32'(4 * $urandom_range(0, 3));
        1:       rpc = INIT_PC + 32'($urandom_range(0, 4 * IMEM_WORDS - 1));
        2:       rpc = $urandom;
        3:       rpc = INIT_PC - 32'(4 * $urandom_range(1, 2));
        default: rpc = INIT_PC + 32'(4 * $urandom_range(0, IMEM_WORDS - 1));
      endcase
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      apply($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
      advance();
    end
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
